alu_result_buffer: RTL and testbench

//  Downstream stage of the 7-bit ALU: captures Resultado plus the four flags
//  (CarryOut, Overflow, Cero, Negativo) into a DEPTH-entry first-word-fall-through FIFO.

---
 rtl/alu_result_buffer.sv | 100 ++++++++++
 tb/tb_alu_result_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   Output stage of the 7-bit ALU. Each accepted ALU result and its four flags
//   go into a first-word-fall-through FIFO. The consumer drains the FIFO over a
//   valid/ready handshake. The block also keeps sticky flags and a saturating
//   count of overflow events for status readout.
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               upstream handshake (in_ready = not full)
//   Resultado, CarryOut, Overflow,
//   Cero, Negativo                  ALU result and flags
//   out_valid/out_ready             downstream handshake (out_valid = not empty)
//   out_Resultado, out_Flags        head entry, flags ordered {N,Z,C,V}; 0 when empty
//   Sticky_Flags, clr_sticky        OR of accepted flags since reset or clear
//   Ovf_Count                       accepted entries with Overflow=1, saturates at 15
//   Count                           occupancy 0..DEPTH
module alu_result_buffer #(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           Resultado,
   input  logic                       CarryOut,
   input  logic                       Overflow,
   input  logic                       Cero,
   input  logic                       Negativo,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_Resultado,
   output logic [3:0]                 out_Flags,
   output logic [3:0]                 Sticky_Flags,
   input  logic                       clr_sticky,
   output logic [3:0]                 Ovf_Count,
   output logic [$clog2(DEPTH):0]     Count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic [3:0]       flags;   // {N,Z,C,V}
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            push, pop;
   logic [3:0]      in_flags;
   entry_t          head;

   assign in_flags  = {Negativo, Cero, CarryOut, Overflow};
   // in_ready depends on Count only: a full FIFO never accepts, even if a pop
   // happens in the same cycle.
   assign in_ready  = (Count != CW'(DEPTH));
   assign out_valid = (Count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign head          = mem[rd_ptr];
   assign out_Resultado = out_valid ? head.res   : '0;
   assign out_Flags     = out_valid ? head.flags : '0;

   // Storage carries no reset; validity is tracked by Count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{res: Resultado, flags: in_flags};
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         Count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   Count <= Count + 1'b1;
            2'b01:   Count <= Count - 1'b1;
            default: Count <= Count;
         endcase
      end
   end

   // A push in the same cycle as a clear wins: sticky restarts from that entry.
   always_ff @(posedge clk) begin
      if (!rst_n)          Sticky_Flags <= '0;
      else if (push)       Sticky_Flags <= (clr_sticky ? 4'b0 : Sticky_Flags) | in_flags;
      else if (clr_sticky) Sticky_Flags <= '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         Ovf_Count <= '0;
      else if (push && Overflow && (Ovf_Count != 4'd15))
         Ovf_Count <= Ovf_Count + 4'd1;
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
   logic       clk = 1'b0;
   logic       rst_n, in_valid, out_ready, clr_sticky;
   logic       CarryOut, Overflow, Cero, Negativo;
   logic [6:0] Resultado;
   logic       in_ready, out_valid;
   logic [6:0] out_Resultado;
   logic [3:0] out_Flags, Sticky_Flags, Ovf_Count;
   logic [2:0] Count;

   alu_result_buffer #(.WIDTH(7), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .Resultado(Resultado), .CarryOut(CarryOut), .Overflow(Overflow),
      .Cero(Cero), .Negativo(Negativo), .out_valid(out_valid), .out_ready(out_ready),
      .out_Resultado(out_Resultado), .out_Flags(out_Flags),
      .Sticky_Flags(Sticky_Flags), .clr_sticky(clr_sticky),
      .Ovf_Count(Ovf_Count), .Count(Count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit mon_en = 0;

   function automatic void chk(string n, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endfunction

   // Scoreboard: expected entries queued as stimulus is accepted.
   logic [10:0] exp_q[$];
   int          mcount = 0;
   logic [3:0]  msticky = 0;
   int          movf = 0;
   bit          mp, mq;

   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         mcount = 0; msticky = 0; movf = 0;
      end else begin
         mp = in_valid && (mcount != 4);
         mq = out_ready && (mcount != 0);
         if (mq) void'(exp_q.pop_front());
         if (mp) exp_q.push_back({Resultado, Negativo, Cero, CarryOut, Overflow});
         mcount = mcount + (mp ? 1 : 0) - (mq ? 1 : 0);
         if (mp) msticky = (clr_sticky ? 4'b0 : msticky) | {Negativo, Cero, CarryOut, Overflow};
         else if (clr_sticky) msticky = 4'b0;
         if (mp && Overflow && movf != 15) movf++;
      end
   end

   // Monitor: compares whatever the DUT presents against the queue head.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_in_ready", int'(in_ready), int'(mcount != 4));
         chk("mon_count", int'(Count), mcount);
         chk("mon_sticky", int'(Sticky_Flags), int'(msticky));
         chk("mon_ovf", int'(Ovf_Count), movf);
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("mon_unexpected_valid", 1, 0);
            else begin
               chk("mon_head_res", int'(out_Resultado), int'(exp_q[0][10:4]));
               chk("mon_head_flags", int'(out_Flags), int'(exp_q[0][3:0]));
            end
         end else begin
            chk("mon_valid", int'(out_valid), int'(mcount != 0));
            chk("mon_empty_res", int'(out_Resultado), 0);
            chk("mon_empty_flags", int'(out_Flags), 0);
         end
      end
   end

   task automatic drv(input logic v, input logic [6:0] r, input logic [3:0] f);
      in_valid = v; Resultado = r;
      Negativo = f[3]; Cero = f[2]; CarryOut = f[1]; Overflow = f[0];
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 0; out_ready = 0; clr_sticky = 0;
      drv(0, 7'h00, 4'h0);
      // 1 reset
      tick(); mon_en = 1;
      tick(); rst_n = 1;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_count", int'(Count), 0);
      chk("rst_sticky", int'(Sticky_Flags), 0);
      chk("rst_ovf", int'(Ovf_Count), 0);
      chk("rst_res", int'(out_Resultado), 0);

      // 2 single entry, one-cycle latency
      drv(1, 7'h2A, 4'b0010); tick(); drv(0, 7'h00, 4'h0);
      @(negedge clk);
      chk("single_valid", int'(out_valid), 1);
      chk("single_res", int'(out_Resultado), 'h2A);
      chk("single_flags", int'(out_Flags), 'b0010);
      chk("single_count", int'(Count), 1);
      out_ready = 1; tick(); out_ready = 0;

      // 3 fill to full, overflowing push ignored, drain in order
      for (int i = 1; i <= 4; i++) begin drv(1, 7'(i), 4'h0); tick(); end
      drv(1, 7'h05, 4'h0); tick();
      @(negedge clk);
      chk("full_count", int'(Count), 4);
      chk("full_in_ready", int'(in_ready), 0);
      drv(0, 7'h00, 4'h0);
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_res", int'(out_Resultado), i);
         tick(); @(negedge clk);
      end
      chk("drain_empty", int'(out_valid), 0);
      out_ready = 0;

      // 4 steady push+pop at Count=2 across pointer wrap
      drv(1, 7'h0A, 4'h0); tick();
      drv(1, 7'h0B, 4'h0); tick();
      out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         drv(1, 7'(8'h10 + i), 4'h0);
         @(negedge clk);
         chk("wrap_res", int'(out_Resultado), (i == 0) ? 'h0A : (i == 1) ? 'h0B : ('h10 + i - 2));
         chk("wrap_count", int'(Count), 2);
         tick();
      end
      drv(0, 7'h00, 4'h0); tick(); tick();
      out_ready = 0;
      @(negedge clk);
      chk("wrap_empty", int'(out_valid), 0);

      // 5 sticky flags
      clr_sticky = 1; tick(); clr_sticky = 0;
      out_ready = 1;
      drv(1, 7'h11, 4'b0001); tick();
      drv(1, 7'h12, 4'b0010); tick();
      drv(0, 7'h00, 4'h0);
      @(negedge clk);
      chk("sticky_or", int'(Sticky_Flags), 'b0011);
      clr_sticky = 1; drv(1, 7'h13, 4'b1000); tick(); drv(0, 7'h00, 4'h0);
      @(negedge clk);
      chk("sticky_push_wins", int'(Sticky_Flags), 'b1000);
      tick(); clr_sticky = 0;
      @(negedge clk);
      chk("sticky_clear", int'(Sticky_Flags), 0);

      // 6 overflow saturation, then reset mid-operation
      for (int i = 0; i < 17; i++) begin drv(1, 7'(i), 4'b0001); tick(); end
      drv(0, 7'h00, 4'h0);
      @(negedge clk);
      chk("ovf_sat", int'(Ovf_Count), 15);
      out_ready = 0; tick();
      drv(1, 7'h21, 4'h0); tick();
      drv(1, 7'h22, 4'h0); tick();
      drv(0, 7'h00, 4'h0);
      @(negedge clk);
      chk("pre_rst_count", int'(Count), 3);
      rst_n = 0; tick(); rst_n = 1;
      @(negedge clk);
      chk("mid_rst_count", int'(Count), 0);
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_ovf", int'(Ovf_Count), 0);
      chk("mid_rst_res", int'(out_Resultado), 0);
      drv(1, 7'h55, 4'b0100); tick(); drv(0, 7'h00, 4'h0);
      @(negedge clk);
      chk("post_rst_res", int'(out_Resultado), 'h55);
      chk("post_rst_flags", int'(out_Flags), 'b0100);
      out_ready = 1; tick(); tick();
      @(negedge clk);
      mon_en = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
